// File: rtl/mat_seq_ctrl_if.sv
// mat_seq_ctrl_if: handshake bundle between the matrix sequencer and its program store,
// datapath and write-back sink.
//   START/INSTR_VALID/INSTRDATA/WB_READY : into the sequencer
//   INSTR_REQ/PC_INS                     : instruction fetch
//   LD_A_EN/LD_B_EN/LD_IDX               : operand row/column load strobes
//   MAC_CLR/MAC_EN/SEQ_K                 : accumulator control
//   WB_EN/WB_IDX                         : result row write-back
//   BUSY/DONE/ERR                        : status
interface mat_seq_ctrl_if #(parameter int N = 16, parameter int PCW = 8);
    localparam int LOGN = $clog2(N);
    logic            START;
    logic            INSTR_REQ;
    logic [PCW-1:0]  PC_INS;
    logic            INSTR_VALID;
    logic [31:0]     INSTRDATA;
    logic            LD_A_EN;
    logic            LD_B_EN;
    logic [LOGN-1:0] LD_IDX;
    logic            MAC_CLR;
    logic            MAC_EN;
    logic [LOGN-1:0] SEQ_K;
    logic            WB_EN;
    logic [LOGN-1:0] WB_IDX;
    logic            WB_READY;
    logic            BUSY;
    logic            DONE;
    logic            ERR;
    modport master (
        input  START, INSTR_VALID, INSTRDATA, WB_READY,
        output INSTR_REQ, PC_INS, LD_A_EN, LD_B_EN, LD_IDX, MAC_CLR, MAC_EN, SEQ_K,
               WB_EN, WB_IDX, BUSY, DONE, ERR
    );
    modport slave (
        output START, INSTR_VALID, INSTRDATA, WB_READY,
        input  INSTR_REQ, PC_INS, LD_A_EN, LD_B_EN, LD_IDX, MAC_CLR, MAC_EN, SEQ_K,
               WB_EN, WB_IDX, BUSY, DONE, ERR
    );
endinterface

// File: rtl/mat_seq_ctrl.sv
// mat_seq_ctrl: instruction sequencer for an N x N SIMD matrix-multiply datapath.
//   CLK  : clock, all state changes on rising edge
//   RSTN : asynchronous active-low reset
//   bus  : mat_seq_ctrl_if master (fetch, load/MAC/write-back strobes, status)
module mat_seq_ctrl #(
    parameter int N   = 16,
    parameter int PCW = 8
) (
    input  logic          CLK,
    input  logic          RSTN,
    mat_seq_ctrl_if.master bus
);
    localparam int LOGN = $clog2(N);
    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MAC   = 3'd3;
    localparam logic [2:0] S_WBK   = 3'd4;
    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_LDB    = 8'h09;
    localparam logic [7:0] OP_LDA    = 8'h0A;
    localparam logic [7:0] OP_MATMUL = 8'h03;
    localparam logic [7:0] OP_WB     = 8'h04;
    localparam logic [7:0] OP_CLR    = 8'h05;
    localparam logic [7:0] OP_HALT   = 8'h80;

    logic [2:0]      state;
    logic [PCW-1:0]  pc;
    logic [7:0]      op;
    logic [LOGN-1:0] idx;
    logic [LOGN-1:0] seq_k;
    logic [LOGN-1:0] wb_idx;
    logic            err;
    logic            known;

    always_comb known = op inside {OP_NOP, OP_LDB, OP_LDA, OP_MATMUL, OP_WB, OP_CLR, OP_HALT};

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= S_IDLE;
            pc     <= '0;
            op     <= '0;
            idx    <= '0;
            seq_k  <= '0;
            wb_idx <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.START) begin
                    pc    <= '0;
                    err   <= 1'b0;
                    state <= S_FETCH;
                end
                S_FETCH: if (bus.INSTR_VALID) begin
                    op    <= bus.INSTRDATA[7:0];
                    idx   <= bus.INSTRDATA[8 +: LOGN];
                    pc    <= pc + 1'b1;
                    // a fetch from the last address has nowhere to continue: abort without DONE
                    if (&pc) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!known) err <= 1'b1;
                    seq_k  <= '0;
                    wb_idx <= '0;
                    state  <= op == OP_HALT   ? S_IDLE :
                              op == OP_MATMUL ? S_MAC  :
                              op == OP_WB     ? S_WBK  : S_FETCH;
                end
                S_MAC: begin
                    seq_k <= seq_k + 1'b1;
                    if (seq_k == LAST) state <= S_FETCH;
                end
                S_WBK: if (bus.WB_READY) begin
                    wb_idx <= wb_idx + 1'b1;
                    if (wb_idx == LAST) state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // every output is a function of registered state only
    assign bus.INSTR_REQ = state == S_FETCH;
    assign bus.PC_INS    = pc;
    assign bus.LD_A_EN   = state == S_EXEC && op == OP_LDA;
    assign bus.LD_B_EN   = state == S_EXEC && op == OP_LDB;
    assign bus.LD_IDX    = idx;
    assign bus.MAC_CLR   = state == S_EXEC && op == OP_CLR;
    assign bus.MAC_EN    = state == S_MAC;
    assign bus.SEQ_K     = seq_k;
    assign bus.WB_EN     = state == S_WBK;
    assign bus.WB_IDX    = wb_idx;
    assign bus.BUSY      = state != S_IDLE;
    assign bus.DONE      = state == S_EXEC && op == OP_HALT;
    assign bus.ERR       = err;
endmodule

// File: tb/tb_mat_seq_ctrl.sv
// tb_mat_seq_ctrl: randomized self-checking bench; a program interpreter predicts every cycle.
module tb_mat_seq_ctrl;
    localparam logic [7:0] OP_NOP = 8'h00, OP_LDB = 8'h09, OP_LDA = 8'h0A, OP_MATMUL = 8'h03;
    localparam logic [7:0] OP_WB = 8'h04, OP_CLR = 8'h05, OP_HALT = 8'h80;

    typedef struct {
        bit v, r, req, busy, done, chk_err, err;
        logic [7:0] pc;
        logic [4:0] str;
        logic [3:0] idx;
    } rec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [31:0] prog [256];
    logic [31:0] progb [4];

    always #5 clk = ~clk;

    mat_seq_ctrl_if #(.N(16), .PCW(8)) bus ();
    mat_seq_ctrl_if #(.N(4), .PCW(2)) bb ();
    assign bus.INSTRDATA = prog[bus.PC_INS];
    assign bb.INSTRDATA  = progb[bb.PC_INS];

    mat_seq_ctrl #(.N(16), .PCW(8)) dut (.CLK(clk), .RSTN(rstn), .bus(bus.master));
    mat_seq_ctrl #(.N(4), .PCW(2)) dut_b (.CLK(clk), .RSTN(rstn), .bus(bb.master));

    function automatic logic [28:0] outs_a();
        return {bus.INSTR_REQ, bus.PC_INS, bus.LD_A_EN, bus.LD_B_EN, bus.LD_IDX, bus.MAC_CLR,
                bus.MAC_EN, bus.SEQ_K, bus.WB_EN, bus.WB_IDX, bus.BUSY, bus.DONE, bus.ERR};
    endfunction

    function automatic rec_t mk(input int v, input bit req, input bit busy, input bit done,
                                input int pc, input logic [4:0] str, input int idx);
        rec_t e;
        e.v = v > 1 ? 1'($urandom_range(0, 1)) : 1'(v);
        e.r = 1'($urandom_range(0, 1));
        e.req = req; e.busy = busy; e.done = done; e.pc = 8'(pc);
        e.str = str; e.idx = 4'(idx); e.chk_err = 0; e.err = 0;
        return e;
    endfunction

    // vmode: 0 valid always high, 1 random fetch waits; stall: extra waits on the first fetch
    // rmode: 0 ready always high, 1 toggles starting high, 2 random
    task automatic run_prog(input string name, input int vmode, input int stall, input int rmode);
        rec_t q[$];
        rec_t e;
        int pc = 0, nw, t = 0;
        bit fin = 0, err = 0, rdy;
        logic [31:0] w;
        logic [7:0] op;
        logic [3:0] ix;
        logic [4:0] so;
        while (!fin) begin
            w = prog[pc]; op = w[7:0]; ix = w[11:8];
            nw = (vmode != 0 ? $urandom_range(0, 3) : 0) + (pc == 0 ? stall : 0);
            for (int i = 0; i < nw; i++) q.push_back(mk(0, 1, 1, 0, pc, 5'b0, 0));
            e = mk(1, 1, 1, 0, pc, 5'b0, 0);
            e.chk_err = pc == 0;
            q.push_back(e);
            case (op)
                OP_LDA: q.push_back(mk(2, 0, 1, 0, 0, 5'b10000, int'(ix)));
                OP_LDB: q.push_back(mk(2, 0, 1, 0, 0, 5'b01000, int'(ix)));
                OP_CLR: q.push_back(mk(2, 0, 1, 0, 0, 5'b00100, 0));
                OP_NOP: q.push_back(mk(2, 0, 1, 0, 0, 5'b0, 0));
                OP_HALT: begin q.push_back(mk(2, 0, 1, 1, 0, 5'b0, 0)); fin = 1; end
                OP_MATMUL: begin
                    q.push_back(mk(2, 0, 1, 0, 0, 5'b0, 0));
                    for (int k = 0; k < 16; k++) q.push_back(mk(2, 0, 1, 0, 0, 5'b00010, k));
                end
                OP_WB: begin
                    q.push_back(mk(2, 0, 1, 0, 0, 5'b0, 0));
                    for (int row = 0; row < 16; row++) begin
                        do begin
                            rdy = rmode == 0 ? 1'b1 : rmode == 1 ? (t % 2 == 0) : 1'($urandom_range(0, 1));
                            t++;
                            e = mk(2, 0, 1, 0, 0, 5'b00001, row);
                            e.r = rdy;
                            q.push_back(e);
                        end while (!rdy);
                    end
                end
                default: begin q.push_back(mk(2, 0, 1, 0, 0, 5'b0, 0)); err = 1; end
            endcase
            pc++;
        end
        e = mk(2, 0, 0, 0, 0, 5'b0, 0);
        e.chk_err = 1; e.err = err;
        q.push_back(e);
        @(negedge clk);
        bus.START = 1;
        foreach (q[i]) begin
            @(negedge clk);
            bus.START = 0;
            so = {bus.LD_A_EN, bus.LD_B_EN, bus.MAC_CLR, bus.MAC_EN, bus.WB_EN};
            checks++;
            if (bus.INSTR_REQ !== q[i].req || bus.BUSY !== q[i].busy || bus.DONE !== q[i].done || so !== q[i].str) begin
                errors++;
                $display("FAIL %s cyc%0d ctl: got req=%b busy=%b done=%b str=%b, want req=%b busy=%b done=%b str=%b",
                         name, i, bus.INSTR_REQ, bus.BUSY, bus.DONE, so, q[i].req, q[i].busy, q[i].done, q[i].str);
            end
            if (q[i].req) begin
                checks++;
                if (bus.PC_INS !== q[i].pc) begin
                    errors++;
                    $display("FAIL %s cyc%0d pc_ins: got %0d want %0d", name, i, bus.PC_INS, q[i].pc);
                end
            end
            if (q[i].str[4] | q[i].str[3]) begin
                checks++;
                if (bus.LD_IDX !== q[i].idx) begin
                    errors++;
                    $display("FAIL %s cyc%0d ld_idx: got %0d want %0d", name, i, bus.LD_IDX, q[i].idx);
                end
            end
            if (q[i].str[1]) begin
                checks++;
                if (bus.SEQ_K !== q[i].idx) begin
                    errors++;
                    $display("FAIL %s cyc%0d seq_k: got %0d want %0d", name, i, bus.SEQ_K, q[i].idx);
                end
            end
            if (q[i].str[0]) begin
                checks++;
                if (bus.WB_IDX !== q[i].idx) begin
                    errors++;
                    $display("FAIL %s cyc%0d wb_idx: got %0d want %0d", name, i, bus.WB_IDX, q[i].idx);
                end
            end
            if (q[i].chk_err) begin
                checks++;
                if (bus.ERR !== q[i].err) begin
                    errors++;
                    $display("FAIL %s cyc%0d err: got %b want %b", name, i, bus.ERR, q[i].err);
                end
            end
            bus.INSTR_VALID = q[i].v;
            bus.WB_READY = q[i].r;
        end
        bus.INSTR_VALID = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (outs_a() !== 29'd0 || bb.BUSY !== 1'b0 || bb.ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %h busy_b=%b err_b=%b, want 0", outs_a(), bb.BUSY, bb.ERR);
        end
        prog[0] = {24'd0, OP_HALT};
        bus.INSTR_VALID = 1;
        rstn = 1;
        bus.START = 1;
        @(negedge clk);
        bus.START = 0;
        checks++;
        if (bus.INSTR_REQ !== 1'b1 || bus.PC_INS !== 8'd0) begin
            errors++;
            $display("FAIL first_start: got req=%b pc=%0d, want req=1 pc=0", bus.INSTR_REQ, bus.PC_INS);
        end
        @(negedge clk);
        checks++;
        if (bus.DONE !== 1'b1) begin
            errors++;
            $display("FAIL halt_done: got %b want 1", bus.DONE);
        end
        @(negedge clk);
        checks++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL halt_idle: got busy=%b done=%b want 0 0", bus.BUSY, bus.DONE);
        end
        bus.INSTR_VALID = 0;
    endtask

    task automatic test_loads();
        prog[0] = {24'h000003, OP_LDB};
        prog[1] = {24'h000005, OP_LDA};
        prog[2] = {24'd0, OP_HALT};
        run_prog("loads", 0, 0, 0);
    endtask

    task automatic test_matmul();
        prog[0] = {24'd0, OP_CLR};
        prog[1] = {24'd0, OP_MATMUL};
        prog[2] = {24'd0, OP_HALT};
        run_prog("matmul", 0, 0, 0);
    endtask

    task automatic test_writeback();
        prog[0] = {24'd0, OP_WB};
        prog[1] = {24'd0, OP_HALT};
        run_prog("wb_toggle", 0, 0, 1);
        run_prog("wb_random", 1, 0, 2);
    endtask

    task automatic test_stall_err();
        prog[0] = {24'd0, 8'h7F};
        prog[1] = {24'h000002, OP_LDA};
        prog[2] = {24'd0, OP_HALT};
        run_prog("stall_err", 0, 5, 0);
    endtask

    task automatic test_random();
        logic [31:0] rnd;
        logic [7:0] op;
        int len;
        for (int p = 0; p < 8; p++) begin
            len = $urandom_range(3, 8);
            for (int i = 0; i < len; i++) begin
                rnd = $urandom;
                case ($urandom_range(0, 6))
                    0: op = OP_NOP;
                    1: op = OP_LDA;
                    2: op = OP_LDB;
                    3: op = OP_CLR;
                    4: op = OP_MATMUL;
                    5: op = OP_WB;
                    default: op = 8'h10 + 8'($urandom_range(0, 15));
                endcase
                prog[i] = {rnd[31:8], op};
            end
            prog[len] = {24'd0, OP_HALT};
            run_prog($sformatf("random%0d", p), 1, 0, 2);
        end
    endtask

    task automatic test_reset_mid_mac();
        bit found = 0;
        prog[0] = {24'd0, 8'h7F};
        prog[1] = {24'd0, OP_MATMUL};
        prog[2] = {24'd0, OP_HALT};
        bus.INSTR_VALID = 1;
        @(negedge clk);
        bus.START = 1;
        @(negedge clk);
        bus.START = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (bus.MAC_EN === 1'b1 && bus.SEQ_K === 4'd7) found = 1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_seq_k7: got timeout want MAC_EN with SEQ_K=7");
        end
        #2 rstn = 0;
        #1;
        checks++;
        if (outs_a() !== 29'd0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0", outs_a());
        end
        bus.INSTR_VALID = 0;
        @(negedge clk);
        rstn = 1;
        prog[0] = {24'h000009, OP_LDA};
        prog[1] = {24'd0, OP_HALT};
        run_prog("restart", 0, 0, 0);
    endtask

    task automatic test_pc_wrap();
        int cyc, macs, dones;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) progb[i] = {24'd0, (p == 0 && i == 0) ? OP_MATMUL : OP_NOP};
            bb.INSTR_VALID = 1;
            @(negedge clk);
            bb.START = 1;
            @(negedge clk);
            bb.START = 0;
            checks++;
            if (bb.INSTR_REQ !== 1'b1 || bb.PC_INS !== 2'd0 || (p == 1 && bb.ERR !== 1'b0)) begin
                errors++;
                $display("FAIL wrap%0d_start: got req=%b pc=%0d err=%b", p, bb.INSTR_REQ, bb.PC_INS, bb.ERR);
            end
            cyc = 0; macs = 0; dones = 0;
            while (bb.BUSY === 1'b1 && cyc < 100) begin
                macs += int'(bb.MAC_EN);
                dones += int'(bb.DONE);
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (cyc != (p == 0 ? 11 : 7) || macs != (p == 0 ? 4 : 0) || dones != 0) begin
                errors++;
                $display("FAIL wrap%0d_run: got cycles=%0d macs=%0d dones=%0d want %0d %0d 0",
                         p, cyc, macs, dones, p == 0 ? 11 : 7, p == 0 ? 4 : 0);
            end
            checks++;
            if (bb.ERR !== 1'b1 || bb.BUSY !== 1'b0 || bb.DONE !== 1'b0) begin
                errors++;
                $display("FAIL wrap%0d_end: got err=%b busy=%b done=%b want 1 0 0", p, bb.ERR, bb.BUSY, bb.DONE);
            end
            bb.INSTR_VALID = 0;
        end
    endtask

    initial begin
        bus.START = 0; bus.INSTR_VALID = 0; bus.WB_READY = 0;
        bb.START = 0; bb.INSTR_VALID = 0; bb.WB_READY = 0;
        test_reset();
        test_loads();
        test_matmul();
        test_writeback();
        test_stall_err();
        test_random();
        test_reset_mid_mac();
        test_pc_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
